// File: rtl/aclk_pkg.sv
// Shared types and limits for the alarm-clock time-of-day counter.
package aclk_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t MIN_LS_MAX      = 4'd9;
    localparam bcd_t MIN_MS_MAX      = 4'd5;
    localparam bcd_t HR_MS_MAX       = 4'd2;
    localparam bcd_t HR_LS_MAX_AT_20 = 4'd3;

    // Two-digit BCD of a binary value 0..99, {tens, units}; used for reset constants.
    function automatic logic [7:0] bin_to_bcd2(input int unsigned v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'((v / 10) % 10);
        units = 4'(v % 10);
        return {tens, units};
    endfunction

endpackage

// File: rtl/aclk_bcd_digit.sv
// One BCD counter digit with load, increment and a runtime wrap limit.
module aclk_bcd_digit
    import aclk_pkg::*;
#(
    parameter bcd_t INIT = 4'd0
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  bcd_t load_val,
    input  logic inc_en,
    input  bcd_t max,
    output bcd_t digit,
    output logic carry
);

    bcd_t digit_q;
    bcd_t digit_d;
    logic at_max;

    // >= rather than == so a digit can never run past its limit if the limit shrinks.
    assign at_max = (digit_q >= max);
    assign carry  = inc_en && at_max;
    assign digit  = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (inc_en) begin
            digit_d = at_max ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= INIT;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/aclk_counter.sv
// 24-hour BCD time-of-day counter advanced by a one-minute strobe, with validated parallel load.
module aclk_counter
    import aclk_pkg::*;
#(
    parameter int unsigned INIT_HOUR = 0,
    parameter int unsigned INIT_MIN  = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic one_minute,
    input  logic load_new_c,
    input  bcd_t new_hr_ms,
    input  bcd_t new_hr_ls,
    input  bcd_t new_min_ms,
    input  bcd_t new_min_ls,
    output bcd_t cur_hr_ms,
    output bcd_t cur_hr_ls,
    output bcd_t cur_min_ms,
    output bcd_t cur_min_ls,
    output logic hour_tick,
    output logic day_tick,
    output logic load_err
);

    localparam logic [7:0] INIT_HR_BCD  = bin_to_bcd2(INIT_HOUR);
    localparam logic [7:0] INIT_MIN_BCD = bin_to_bcd2(INIT_MIN);

    logic load_valid;
    logic load_ok;
    logic inc;
    logic min_ls_carry;
    logic min_ms_carry;
    logic hr_ls_carry;
    logic hr_ms_carry;
    bcd_t hr_ls_max;

    logic hour_tick_q;
    logic day_tick_q;
    logic load_err_q;

    assign load_valid = (new_hr_ms <= HR_MS_MAX) && (new_hr_ls <= MIN_LS_MAX) &&
                        (new_min_ms <= MIN_MS_MAX) && (new_min_ls <= MIN_LS_MAX) &&
                        !((new_hr_ms == HR_MS_MAX) && (new_hr_ls > HR_LS_MAX_AT_20));

    assign load_ok = load_new_c && load_valid;
    // Any load request, accepted or not, swallows a same-cycle minute strobe.
    assign inc     = one_minute && !load_new_c;

    assign hr_ls_max = (cur_hr_ms == HR_MS_MAX) ? HR_LS_MAX_AT_20 : MIN_LS_MAX;

    aclk_bcd_digit #(.INIT(INIT_MIN_BCD[3:0])) u_min_ls (
        .clk      (clk),
        .reset    (reset),
        .load     (load_ok),
        .load_val (new_min_ls),
        .inc_en   (inc),
        .max      (MIN_LS_MAX),
        .digit    (cur_min_ls),
        .carry    (min_ls_carry)
    );

    aclk_bcd_digit #(.INIT(INIT_MIN_BCD[7:4])) u_min_ms (
        .clk      (clk),
        .reset    (reset),
        .load     (load_ok),
        .load_val (new_min_ms),
        .inc_en   (min_ls_carry),
        .max      (MIN_MS_MAX),
        .digit    (cur_min_ms),
        .carry    (min_ms_carry)
    );

    aclk_bcd_digit #(.INIT(INIT_HR_BCD[3:0])) u_hr_ls (
        .clk      (clk),
        .reset    (reset),
        .load     (load_ok),
        .load_val (new_hr_ls),
        .inc_en   (min_ms_carry),
        .max      (hr_ls_max),
        .digit    (cur_hr_ls),
        .carry    (hr_ls_carry)
    );

    aclk_bcd_digit #(.INIT(INIT_HR_BCD[7:4])) u_hr_ms (
        .clk      (clk),
        .reset    (reset),
        .load     (load_ok),
        .load_val (new_hr_ms),
        .inc_en   (hr_ls_carry),
        .max      (HR_MS_MAX),
        .digit    (cur_hr_ms),
        .carry    (hr_ms_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hour_tick_q <= 1'b0;
            day_tick_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            hour_tick_q <= min_ms_carry;
            day_tick_q  <= hr_ms_carry;
            load_err_q  <= load_new_c && !load_valid;
        end
    end

    assign hour_tick = hour_tick_q;
    assign day_tick  = day_tick_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_aclk_counter.sv
// Directed bench for aclk_counter: binary reference model feeds a scoreboard queue.
module tb_aclk_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       one_minute = 1'b0;
    logic       load_new_c = 1'b0;
    logic [3:0] new_hr_ms = '0;
    logic [3:0] new_hr_ls = '0;
    logic [3:0] new_min_ms = '0;
    logic [3:0] new_min_ls = '0;
    logic [3:0] cur_hr_ms;
    logic [3:0] cur_hr_ls;
    logic [3:0] cur_min_ms;
    logic [3:0] cur_min_ls;
    logic       hour_tick;
    logic       day_tick;
    logic       load_err;

    typedef struct packed {
        logic [3:0] hms;
        logic [3:0] hls;
        logic [3:0] mms;
        logic [3:0] mls;
        logic       ht;
        logic       dt;
        logic       le;
    } obs_t;

    obs_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   mh = 0;
    int   mm = 0;
    int   ht_cnt = 0;
    int   dt_cnt = 0;

    always #5 clk = ~clk;

    aclk_counter #(.INIT_HOUR(0), .INIT_MIN(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .one_minute (one_minute),
        .load_new_c (load_new_c),
        .new_hr_ms  (new_hr_ms),
        .new_hr_ls  (new_hr_ls),
        .new_min_ms (new_min_ms),
        .new_min_ls (new_min_ls),
        .cur_hr_ms  (cur_hr_ms),
        .cur_hr_ls  (cur_hr_ls),
        .cur_min_ms (cur_min_ms),
        .cur_min_ls (cur_min_ls),
        .hour_tick  (hour_tick),
        .day_tick   (day_tick),
        .load_err   (load_err)
    );

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: model predicts, scoreboard holds, DUT output compared after the edge.
    task automatic step(input string tag, input logic rst, input logic ld, input logic om,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
        obs_t e;
        obs_t o;
        logic ok;
        @(negedge clk);
        reset      = rst;
        load_new_c = ld;
        one_minute = om;
        new_hr_ms  = a;
        new_hr_ls  = b;
        new_min_ms = c;
        new_min_ls = d;
        e = '0;
        ok = (a <= 2) && (b <= 9) && (c <= 5) && (d <= 9) && !(a == 2 && b > 3);
        if (rst) begin
            mh = 0;
            mm = 0;
        end else if (ld) begin
            if (ok) begin
                mh = int'(a) * 10 + int'(b);
                mm = int'(c) * 10 + int'(d);
            end else begin
                e.le = 1'b1;
            end
        end else if (om) begin
            mm++;
            if (mm == 60) begin
                mm = 0;
                e.ht = 1'b1;
                mh++;
                if (mh == 24) begin
                    mh = 0;
                    e.dt = 1'b1;
                end
            end
        end
        e.hms = 4'(mh / 10);
        e.hls = 4'(mh % 10);
        e.mms = 4'(mm / 10);
        e.mls = 4'(mm % 10);
        q.push_back(e);
        @(posedge clk);
        #1;
        o = {cur_hr_ms, cur_hr_ls, cur_min_ms, cur_min_ls, hour_tick, day_tick, load_err};
        if (hour_tick === 1'b1) ht_cnt++;
        if (day_tick === 1'b1) dt_cnt++;
        e = q.pop_front();
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h:%h:%h:%h ht=%b dt=%b le=%b expected=%h:%h:%h:%h ht=%b dt=%b le=%b",
                   tag, o.hms, o.hls, o.mms, o.mls, o.ht, o.dt, o.le,
                   e.hms, e.hls, e.mms, e.mls, e.ht, e.dt, e.le);
        end
    endtask

    initial begin
        // T1 reset state and mid-count reset
        step("reset", 1, 0, 0, 0, 0, 0, 0);
        step("hold_after_reset", 0, 0, 0, 0, 0, 0, 0);
        step("load_12_34", 0, 1, 0, 1, 2, 3, 4);
        step("tick_12_35", 0, 0, 1, 0, 0, 0, 0);
        step("reset_mid_count", 1, 0, 1, 0, 0, 0, 0);

        // T2 sixty minutes from midnight
        ht_cnt = 0;
        dt_cnt = 0;
        for (int i = 0; i < 60; i++) step("hour_roll", 0, 0, 1, 0, 0, 0, 0);
        chk_int("hour_tick_count_t2", ht_cnt, 1);
        chk_int("day_tick_count_t2", dt_cnt, 0);

        // T3 day wrap and 09:59 -> 10:00
        step("load_23_59", 0, 1, 0, 2, 3, 5, 9);
        step("day_wrap", 0, 0, 1, 0, 0, 0, 0);
        step("load_09_59", 0, 1, 0, 0, 9, 5, 9);
        step("wrap_to_10_00", 0, 0, 1, 0, 0, 0, 0);
        step("load_19_59", 0, 1, 0, 1, 9, 5, 9);
        step("wrap_to_20_00", 0, 0, 1, 0, 0, 0, 0);

        // T4 load beats same-cycle minute strobe
        step("load_05_10", 0, 1, 0, 0, 5, 1, 0);
        step("load_with_tick", 0, 1, 1, 0, 7, 4, 5);
        step("hold_07_45", 0, 0, 0, 0, 0, 0, 0);
        step("held_load_1", 0, 1, 1, 0, 0, 0, 0);
        step("held_load_2", 0, 1, 1, 0, 0, 0, 0);

        // T5 rejected and accepted loads
        step("load_11_11", 0, 1, 0, 1, 1, 1, 1);
        step("bad_24_00", 0, 1, 0, 2, 4, 0, 0);
        step("bad_12_60", 0, 1, 0, 1, 2, 6, 0);
        step("bad_1A_00", 0, 1, 1, 1, 4'hA, 0, 0);
        step("bad_30_00", 0, 1, 0, 3, 0, 0, 0);
        step("bad_05_0F", 0, 1, 0, 0, 5, 0, 4'hF);
        step("err_clears", 0, 0, 0, 0, 0, 0, 0);
        step("good_20_00", 0, 1, 0, 2, 0, 0, 0);
        step("good_23_00", 0, 1, 0, 2, 3, 0, 0);

        // T6 fast watch, full day
        step("reset_t6", 1, 0, 0, 0, 0, 0, 0);
        ht_cnt = 0;
        dt_cnt = 0;
        for (int i = 0; i < 1440; i++) step("fast_watch", 0, 0, 1, 0, 0, 0, 0);
        chk_int("hour_tick_count_t6", ht_cnt, 24);
        chk_int("day_tick_count_t6", dt_cnt, 1);
        chk_int("scoreboard_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
